// File: rtl/simple_rr_sequencer.sv
// Round-robin sequencer sharing one external 4-bit transform unit among NUM_REQ requesters.
// The winner's operand goes to dp_a; dp_b is captured DP_LATENCY edges later and returned with its requester index.
module simple_rr_sequencer #(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 1,
  parameter int ID_W       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [3:0]           dp_a,
  input  logic [3:0]           dp_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  localparam int              CNT_W    = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DP_LATENCY - 1);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [3:0]       dp_a_q, dp_a_d;
  logic [3:0]       rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       operand [NUM_REQ];
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [3:0]       win_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_operand
      assign operand[gi] = req_data[4*gi +: 4];
    end
  endgenerate

  // Indices above ptr take precedence; otherwise the lowest set index wins (wrap-around).
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) > ptr_q)) begin
        found    = 1'b1;
        winner   = ID_W'(i);
        win_data = operand[i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        winner   = ID_W'(i);
        win_data = operand[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dp_a_d      = dp_a_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    gnt         = '0;
    case (state_q)
      S_IDLE: begin
        if (found && !rst) begin
          gnt      = NUM_REQ'(1) << winner;
          dp_a_d   = win_data;
          rsp_id_d = winner;
          ptr_d    = winner;
          cnt_d    = CNT_LOAD;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_data_d  = dp_b;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_RST;
      dp_a_q      <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dp_a_q      <= dp_a_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dp_a      = dp_a_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = !rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_simple_rr_sequencer.sv
// Scoreboard bench: two sequencers (latency 1 and 3) with bench-modelled transform units.
// Stimulus pushes expected {id,data}; negedge monitors pop and compare on each accepted response.
module tb_simple_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Latency-1 instance, unit model dp_b = ~dp_a
  logic [3:0]  req, gnt, dp_a, dp_b, rsp_data;
  logic [15:0] req_data;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;

  // Latency-3 instance, unit model driven procedurally
  logic [3:0]  req3, gnt3, dp_a3, dp_b3, rsp_data3;
  logic [15:0] req_data3;
  logic        rsp_valid3, rsp_ready3, busy3;
  logic [1:0]  rsp_id3;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q1[$];
  logic [5:0] exp_q3[$];
  logic [5:0] e1, e3;

  assign dp_b = ~dp_a;

  simple_rr_sequencer #(.NUM_REQ(4), .DP_LATENCY(1), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .dp_a(dp_a), .dp_b(dp_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  simple_rr_sequencer #(.NUM_REQ(4), .DP_LATENCY(3), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .gnt(gnt3),
    .dp_a(dp_a3), .dp_b(dp_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_id(rsp_id3), .busy(busy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Full latency-1 transaction starting in an IDLE cycle with rsp_ready=1.
  task automatic issue(input logic [3:0] reqv, input logic [1:0] win,
                       input logic [3:0] exp_a, input logic [3:0] exp_rsp);
    logic [3:0] onehot;
    onehot = 4'b0001 << win;
    req = reqv;
    #1;
    check("gnt idle", gnt, onehot);
    exp_q1.push_back({win, exp_rsp});
    $display("grant req=%b -> id %0d, operand %h", reqv, win, exp_a);
    step();
    check("dp_a after grant", dp_a, exp_a);
    check("busy wait", busy, 1);
    check("gnt wait", gnt, 0);
    step();
    check("rsp_valid resp", rsp_valid, 1);
    step();
    check("rsp_valid drop", rsp_valid, 0);
    check("busy idle", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      $display("dut1 response id=%0d data=%b", rsp_id, rsp_data);
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected response: got id=%0d data=%h, expected none", rsp_id, rsp_data);
      end else begin
        e1 = exp_q1.pop_front();
        check("dut1 rsp_id", rsp_id, e1[5:4]);
        check("dut1 rsp_data", rsp_data, e1[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid3 && rsp_ready3) begin
      $display("dut3 response id=%0d data=%b", rsp_id3, rsp_data3);
      if (exp_q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3 unexpected response: got id=%0d data=%h, expected none", rsp_id3, rsp_data3);
      end else begin
        e3 = exp_q3.pop_front();
        check("dut3 rsp_id", rsp_id3, e3[5:4]);
        check("dut3 rsp_data", rsp_data3, e3[3:0]);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req        = 4'b1111;
    req_data   = 16'h9A53;   // op0=3 op1=5 op2=A op3=9
    rsp_ready  = 1'b1;
    req3       = 4'b0000;
    req_data3  = 16'h0003;
    dp_b3      = 4'b0110;
    rsp_ready3 = 1'b1;

    // Reset with all requests high
    step();
    step();
    check("reset gnt", gnt, 0);
    check("reset busy", busy, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset dp_a", dp_a, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_id", rsp_id, 0);
    rst = 1'b0;

    // Fairness: grants 0,1,2,3,0,1 spaced three cycles apart
    issue(4'b1111, 2'd0, 4'h3, 4'hC);
    issue(4'b1111, 2'd1, 4'h5, 4'hA);
    issue(4'b1111, 2'd2, 4'hA, 4'h5);
    issue(4'b1111, 2'd3, 4'h9, 4'h6);
    issue(4'b1111, 2'd0, 4'h3, 4'hC);
    issue(4'b1111, 2'd1, 4'h5, 4'hA);

    // Single request from requester 2
    issue(4'b0100, 2'd2, 4'b1010, 4'b0101);

    // Backpressure
    req       = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    check("bp gnt", gnt, 4'b1000);
    exp_q1.push_back({2'd3, 4'h6});
    step();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_data", rsp_data, 4'h6);
      check("bp rsp_id", rsp_id, 3);
      check("bp busy", busy, 1);
      check("bp gnt", gnt, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp next gnt", gnt, 4'b0001);

    // Abort: grant requester 1, reset during WAIT
    req = 4'b0010;
    #1;
    check("abort gnt", gnt, 4'b0010);
    step();
    check("abort dp_a", dp_a, 4'h5);
    check("abort busy", busy, 1);
    rst = 1'b1;
    step();
    check("abort rsp_valid", rsp_valid, 0);
    check("abort busy rst", busy, 0);
    check("abort gnt rst", gnt, 0);
    check("abort dp_a rst", dp_a, 0);
    rst = 1'b0;
    issue(4'b0011, 2'd0, 4'h3, 4'hC);
    req = 4'b0000;

    // Latency 3 instance: wrong dp_b until just before the third edge
    req3 = 4'b0001;
    #1;
    check("lat3 gnt", gnt3, 4'b0001);
    exp_q3.push_back({2'd0, 4'b1100});
    step();
    req3 = 4'b0000;
    check("lat3 dp_a", dp_a3, 4'b0011);
    check("lat3 valid e0", rsp_valid3, 0);
    dp_b3 = 4'b1001;
    step();
    check("lat3 valid e1", rsp_valid3, 0);
    dp_b3 = 4'b0111;
    step();
    check("lat3 valid e2", rsp_valid3, 0);
    dp_b3 = dp_a3 ^ 4'b1111;
    step();
    check("lat3 valid e3", rsp_valid3, 1);
    check("lat3 rsp_data", rsp_data3, 4'b1100);
    dp_b3 = 4'b0110;
    step();
    check("lat3 valid drop", rsp_valid3, 0);

    step();
    step();
    check("dut1 queue drained", exp_q1.size(), 0);
    check("dut3 queue drained", exp_q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_rr_sequencer.md
Name: simple_rr_sequencer

Overview:
Shares one 4-bit combinational "simple" transform unit (4-bit operand in, 4-bit result out) among NUM_REQ requesters. Each requester presents a 4-bit operand. The block arbitrates round-robin, drives the winning operand onto the shared unit, and waits a fixed settle latency. It then captures the result and returns it, tagged with the requester index, over a valid/ready response port. The shared unit is instantiated outside this block, so the bench can substitute a reference model.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DP_LATENCY, 1, cycles from the dp_a update edge to the dp_b sample edge (>=1)
ID_W, 2, width of rsp_id (must be >= clog2(NUM_REQ))

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-high
req  input  NUM_REQ  per-requester request; held high with its operand stable until granted
req_data  input  4*NUM_REQ  operands; requester i uses bits [4i+3:4i]
gnt  output  NUM_REQ  one-hot acceptance strobe, combinational, IDLE state only
dp_a  output  4  operand driven to the shared unit (registered)
dp_b  input  4  result from the shared unit
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts the response
rsp_data  output  4  captured dp_b
rsp_id  output  ID_W  index of the requester served
busy  output  1  high in the WAIT and RESP states

Behaviour:
- Reset (rst high at an edge): state=IDLE, ptr=NUM_REQ-1, dp_a=0, rsp_valid=0, rsp_data=0, rsp_id=0, cnt=0. During reset, gnt=0 and busy=0.
- Reset mid-operation aborts the transaction. No response is produced, and the operand in flight is lost.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If req is nonzero, gnt is one-hot for the first set index searching ptr+1, ptr+2, ... with wrap-around modulo NUM_REQ.
  - At that edge: dp_a<=req_data[winner], rsp_id<=winner, ptr<=winner, cnt<=DP_LATENCY-1, state<=WAIT.
  - If req is zero, gnt=0 and the block stays in IDLE.
- WAIT:
  - gnt=0; req is ignored; dp_a is held.
  - While cnt!=0, cnt decrements each cycle.
  - When cnt==0: rsp_data<=dp_b, rsp_valid<=1, state<=RESP.
  - dp_b is therefore sampled exactly DP_LATENCY edges after the grant edge.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are stable.
  - On an edge with rsp_ready=1: rsp_valid<=0, state<=IDLE.
  - There is no combined RESP->grant path.
- Latency: the grant edge is edge 0, and rsp_valid is visible after edge DP_LATENCY.
- Minimum issue interval is DP_LATENCY+2 cycles per transaction.
- dp_a holds its last operand between transactions. It changes only on a grant edge or on reset.
- The winner is the only requester whose gnt bit is set. Non-winners must keep req held.
- Requesters that deassert before being granted are simply not served; this is not an error.
- A request raised in the same cycle the FSM returns to IDLE is eligible in that IDLE cycle.
- ptr updates only on grant. The requester just served has the lowest priority at the next arbitration.
- Deasserting rsp_ready never drops or alters a pending response.

Test Plan:
1. Reset: hold rst 2 cycles with req=4'b1111.
   -> gnt=0, busy=0, rsp_valid=0, dp_a=0, rsp_data=0, rsp_id=0. The first grant after release goes to requester 0.
2. Single request: bench models dp_b=~dp_a, DP_LATENCY=1. Drive req=4'b0100 with operand 4'b1010 for requester 2, rsp_ready=1.
   -> gnt=4'b0100 in the first IDLE cycle.
   -> dp_a=4'b1010 after that edge.
   -> rsp_valid=1, rsp_data=4'b0101, rsp_id=2 one edge later.
   -> rsp_valid=0 the following cycle.
3. Fairness: req=4'b1111 held continuously (each requester re-requests after its grant), rsp_ready=1.
   -> grant order 0,1,2,3,0,1.
   -> exactly one gnt bit per IDLE cycle.
   -> grants spaced DP_LATENCY+2 cycles apart.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
   -> rsp_valid, rsp_data and rsp_id stay stable.
   -> busy=1 and gnt=0 throughout.
   -> the next grant occurs in the cycle after rsp_ready=1 is seen.
5. Abort: assert rst for 1 cycle while in WAIT after granting requester 1.
   -> no rsp_valid pulse.
   -> with req=4'b0011 afterwards, the next grant goes to requester 0.
6. Latency parameter: DP_LATENCY=3, bench model dp_b=dp_a^4'b1111, operand 4'b0011.
   -> rsp_valid rises 3 edges after the grant edge.
   -> rsp_data=4'b1100.
   -> dp_b values driven before the third edge must not be captured.
